hazard_control: RTL and testbench
=================================

HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-002 The module SHALL have parameter TMO_LIM, default 255, FREEZE cycles before timeout.
REQ-003 The module SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-004 The module SHALL have port reset  in  1  synchronous reset, active-high.
REQ-005 The module SHALL have ports id_rs, id_rt  in  5 each  ID-stage source register addresses.
REQ-006 The module SHALL have port id_uses_rt  in  1  ID instruction reads rt.
REQ-007 The module SHALL have port id_is_branch  in  1  ID instruction is a branch compared in ID.
REQ-008 The module SHALL have port branch_taken  in  1  ID branch outcome.
REQ-009 The module SHALL have ports ex_mem_read, ex_reg_write  in  1 each, plus ex_write_reg  in  5  (ID/EX destination).
REQ-010 The module SHALL have ports mem_mem_read  in  1, plus mem_write_reg  in  5  (EX/MEM destination).
REQ-011 The module SHALL have ports dmem_req, dmem_ready  in  1 each  data-memory handshake in MEM.
REQ-012 The module SHALL have ports pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage write enables.
REQ-013 The module SHALL have ports ifid_flush, idex_bubble  out  1 each  zero IF/ID; insert NOP into ID/EX.
REQ-014 The module SHALL have ports stall_cnt, flush_cnt  out  CNT_W each, plus timeout  out  1  (sticky).

Function
REQ-015 The module SHALL define match(r) = (r != 0) && (r == id_rs || (id_uses_rt && r == id_rt)).
REQ-016 The module SHALL define hz = (ex_mem_read && match(ex_write_reg)) || (id_is_branch && ex_reg_write && match(ex_write_reg)) || (id_is_branch && mem_mem_read && match(mem_write_reg)).
REQ-017 The module SHALL implement states RUN and FREEZE; outputs SHALL be combinational from state and inputs with no added latency.
REQ-018 RUN with dmem_req && !dmem_ready: all five enables 0, flush and bubble 0, next state FREEZE; this takes priority over hz and flush.
REQ-019 In FREEZE, all enables SHALL equal dmem_ready and flush and bubble SHALL be 0; dmem_ready=1 returns to RUN next cycle.
REQ-020 RUN, no freeze, hz=1: pc_en=0, ifid_en=0, idex_bubble=1, idex_en/exmem_en/memwb_en=1, ifid_flush=0.
REQ-021 RUN, no freeze, hz=0, id_is_branch && branch_taken: ifid_flush=1, all enables 1.
REQ-022 RUN otherwise: all enables 1, flush and bubble 0.
REQ-023 A load feeding a branch SHALL therefore stall two cycles (rule a, then rule c), re-evaluated every cycle, no internal count.
REQ-024 stall_cnt SHALL increment each cycle pc_en=0, saturating at all-ones.
REQ-025 flush_cnt SHALL increment each cycle ifid_flush=1, saturating at all-ones.
REQ-026 An internal 8-bit freeze counter SHALL clear on entering FREEZE and increment each FREEZE cycle with dmem_ready=0; on reaching TMO_LIM, timeout SHALL set and stay 1 until reset; state is unchanged.
REQ-027 A register address of 0 SHALL never cause hz.

Reset
REQ-028 With reset=1 at a clock edge: state RUN, stall_cnt=0, flush_cnt=0, freeze counter=0, timeout=0.
REQ-029 While reset=1, outputs SHALL be all enables 1, ifid_flush=1, idex_bubble=1, regardless of state; reset mid-FREEZE discards the freeze.

Structure
REQ-030 State encoding (RUN=0, FREEZE=1), REG_ZERO and TMO_LIM default SHALL live in shared package mips_pkg.
REQ-031 match() SHALL be one sub-module hz_match (5-bit addr, rs, rt, uses_rt -> hit), instantiated twice.

Verification
REQ-032 ex_mem_read=1, ex_write_reg=8, id_rs=8 -> pc_en=0, ifid_en=0, idex_bubble=1 one cycle; stall_cnt=1.
REQ-033 Branch id_rt=9, id_uses_rt=1, load in EX writing 9 -> two stall cycles (load moves to MEM), then flush if branch_taken=1; stall_cnt=2, flush_cnt=1.
REQ-034 ex_write_reg=0, ex_mem_read=1, id_rs=0 -> no stall, all enables 1.
REQ-035 dmem_req=1, dmem_ready=0 for 3 cycles while hz=1 -> enables 0, bubble 0 for 3 cycles; RUN on ready; stall_cnt=3 before hz cycle.
REQ-036 dmem_ready=0 for 300 cycles -> timeout=1 after 255 FREEZE cycles, stays 1 after ready; reset clears it.
REQ-037 Preload stall_cnt to all-ones via 65535+ stalls (CNT_W=4: 16 stalls) -> counter holds at 15.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared pipeline-control definitions: FSM encoding, register constants and the
// control-word layout driven by the hazard unit.
package mips_pkg;

    localparam int unsigned REG_W       = 5;
    localparam int unsigned FRZ_W       = 8;
    localparam int unsigned TMO_LIM_DEF = 255;

    localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

    typedef enum logic {
        RUN    = 1'b0,
        FREEZE = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_bubble;
    } ctrl_t;

    // Value forced while reset is held: pipeline advances and is cleared.
    localparam ctrl_t CTRL_RESET = '{
        pc_en:       1'b1,
        ifid_en:     1'b1,
        idex_en:     1'b1,
        exmem_en:    1'b1,
        memwb_en:    1'b1,
        ifid_flush:  1'b1,
        idex_bubble: 1'b1
    };

    // All five stage enables set to en, no flush, no bubble.
    function automatic ctrl_t ctrl_en(input logic en);
        ctrl_t c;
        c.pc_en       = en;
        c.ifid_en     = en;
        c.idex_en     = en;
        c.exmem_en    = en;
        c.memwb_en    = en;
        c.ifid_flush  = 1'b0;
        c.idex_bubble = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/hz_match.sv
// Does a pipeline destination register feed one of the ID-stage sources?
// Register zero never matches.
module hz_match
    import mips_pkg::*;
(
    input  logic [REG_W-1:0] addr,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             uses_rt,
    output logic             hit
);

    assign hit = (addr != REG_ZERO) && ((addr == rs) || (uses_rt && (addr == rt)));

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard unit: load-use / branch-operand stalls, taken-branch flush,
// data-memory freeze with sticky timeout, and saturating stall/flush counters.
module hazard_control
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TMO_LIM = TMO_LIM_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             branch_taken,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [REG_W-1:0] ex_write_reg,
    input  logic             mem_mem_read,
    input  logic [REG_W-1:0] mem_write_reg,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             timeout
);

    typedef logic [FRZ_W:0] tmo_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [FRZ_W-1:0] FRZ_MAX = '1;
    localparam tmo_t             TMO_CMP = tmo_t'(TMO_LIM);

    hz_state_e        state;
    hz_state_e        state_nxt;
    ctrl_t            ctrl;
    logic             ex_hit;
    logic             mem_hit;
    logic             hz;
    logic             freeze_req;
    logic [FRZ_W-1:0] frz_cnt;
    logic [FRZ_W-1:0] frz_inc;

    hz_match u_match_ex (
        .addr    (ex_write_reg),
        .rs      (id_rs),
        .rt      (id_rt),
        .uses_rt (id_uses_rt),
        .hit     (ex_hit)
    );

    hz_match u_match_mem (
        .addr    (mem_write_reg),
        .rs      (id_rs),
        .rt      (id_rt),
        .uses_rt (id_uses_rt),
        .hit     (mem_hit)
    );

    // Load-use in EX, or a branch in ID waiting on an ALU result in EX or a load in MEM.
    assign hz = (ex_mem_read && ex_hit)
             || (id_is_branch && ex_reg_write && ex_hit)
             || (id_is_branch && mem_mem_read && mem_hit);

    assign freeze_req = dmem_req && !dmem_ready;
    assign frz_inc    = frz_cnt + FRZ_W'(1);

    // Next state and control word; memory freeze outranks hazards, hazards outrank flush.
    always_comb begin
        ctrl      = ctrl_en(1'b1);
        state_nxt = state;
        if (reset) begin
            ctrl      = CTRL_RESET;
            state_nxt = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (freeze_req) begin
                        ctrl      = ctrl_en(1'b0);
                        state_nxt = FREEZE;
                    end else if (hz) begin
                        ctrl.pc_en       = 1'b0;
                        ctrl.ifid_en     = 1'b0;
                        ctrl.idex_bubble = 1'b1;
                    end else if (id_is_branch && branch_taken) begin
                        ctrl.ifid_flush = 1'b1;
                    end
                end
                FREEZE: begin
                    ctrl = ctrl_en(dmem_ready);
                    if (dmem_ready) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    assign pc_en       = ctrl.pc_en;
    assign ifid_en     = ctrl.ifid_en;
    assign idex_en     = ctrl.idex_en;
    assign exmem_en    = ctrl.exmem_en;
    assign memwb_en    = ctrl.memwb_en;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_bubble = ctrl.idex_bubble;

    // State, saturating performance counters and freeze watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
            frz_cnt   <= '0;
            timeout   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!ctrl.pc_en && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ctrl.ifid_flush && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if ((state == RUN) && (state_nxt == FREEZE)) begin
                frz_cnt <= '0;
            end else if ((state == FREEZE) && !dmem_ready && (frz_cnt != FRZ_MAX)) begin
                frz_cnt <= frz_inc;
                if ({1'b0, frz_inc} >= TMO_CMP) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_control.sv
// Bench for hazard_control: vector table for single-cycle decisions plus
// sequences for multi-cycle stalls, freeze, timeout and counter saturation.
module tb_hazard_control;

    localparam int unsigned CW = 4;

    localparam logic [6:0] EN = 7'b11111_00;
    localparam logic [6:0] ST = 7'b00111_01;
    localparam logic [6:0] FL = 7'b11111_10;
    localparam logic [6:0] FZ = 7'b00000_00;
    localparam logic [6:0] RS = 7'b11111_11;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    id_rs, id_rt, ex_write_reg, mem_write_reg;
    logic          id_uses_rt, id_is_branch, branch_taken;
    logic          ex_mem_read, ex_reg_write, mem_mem_read, dmem_req, dmem_ready;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic          timeout;

    always #5 clk = ~clk;

    hazard_control #(.CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .id_is_branch  (id_is_branch),
        .branch_taken  (branch_taken),
        .ex_mem_read   (ex_mem_read),
        .ex_reg_write  (ex_reg_write),
        .ex_write_reg  (ex_write_reg),
        .mem_mem_read  (mem_mem_read),
        .mem_write_reg (mem_write_reg),
        .dmem_req      (dmem_req),
        .dmem_ready    (dmem_ready),
        .pc_en         (pc_en),
        .ifid_en       (ifid_en),
        .idex_en       (idex_en),
        .exmem_en      (exmem_en),
        .memwb_en      (memwb_en),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
        .timeout       (timeout)
    );

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
        logic       br;
        logic       tk;
        logic       exm;
        logic       exw;
        logic [4:0] exr;
        logic       mm;
        logic [4:0] mr;
        logic       rq;
        logic       rd;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [6:0] exp;
    } vec_t;

    logic [6:0] exp_q[$];
    vec_t       vecs[$];
    int         errors = 0;
    int         checks = 0;

    function automatic in_t iv(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                               input logic br, input logic tk, input logic exm, input logic exw,
                               input logic [4:0] exr, input logic mm, input logic [4:0] mr,
                               input logic rq, input logic rd);
        in_t v;
        v.rs = rs; v.rt = rt; v.ur = ur; v.br = br; v.tk = tk;
        v.exm = exm; v.exw = exw; v.exr = exr; v.mm = mm; v.mr = mr;
        v.rq = rq; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name);
        logic [6:0] act;
        logic [6:0] e;
        act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, ctrl=%b", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL %s: ctrl=%b expected %b", name, act, e);
            end
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1 so counters reflect this cycle.
    task automatic apply(input in_t v, input logic rst, input logic [6:0] e, input string name);
        reset         = rst;
        id_rs         = v.rs;
        id_rt         = v.rt;
        id_uses_rt    = v.ur;
        id_is_branch  = v.br;
        branch_taken  = v.tk;
        ex_mem_read   = v.exm;
        ex_reg_write  = v.exw;
        ex_write_reg  = v.exr;
        mem_mem_read  = v.mm;
        mem_write_reg = v.mr;
        dmem_req      = v.rq;
        dmem_ready    = v.rd;
        exp_q.push_back(e);
        @(negedge clk);
        check_out(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t idle, lu, bt;
        int  m_stall, m_flush;

        idle = iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lu   = iv(8, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0, 0);
        bt   = iv(1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);

        vecs.push_back('{in: idle,                                          exp: EN});
        vecs.push_back('{in: lu,                                            exp: ST});
        vecs.push_back('{in: iv(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0),        exp: EN});
        vecs.push_back('{in: iv(1, 9, 0, 0, 0, 1, 1, 9, 0, 0, 0, 0),        exp: EN});
        vecs.push_back('{in: iv(1, 9, 1, 0, 0, 1, 1, 9, 0, 0, 0, 0),        exp: ST});
        vecs.push_back('{in: iv(5, 2, 1, 1, 0, 0, 1, 5, 0, 0, 0, 0),        exp: ST});
        vecs.push_back('{in: iv(5, 2, 1, 0, 0, 0, 1, 5, 0, 0, 0, 0),        exp: EN});
        vecs.push_back('{in: iv(1, 7, 1, 1, 0, 0, 0, 0, 1, 7, 0, 0),        exp: ST});
        vecs.push_back('{in: iv(7, 1, 1, 0, 0, 0, 0, 0, 1, 7, 0, 0),        exp: EN});
        vecs.push_back('{in: iv(1, 2, 1, 1, 1, 0, 1, 3, 1, 4, 0, 0),        exp: FL});
        vecs.push_back('{in: iv(3, 2, 1, 1, 1, 0, 1, 3, 0, 0, 0, 0),        exp: ST});
        vecs.push_back('{in: iv(1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0),        exp: EN});
        vecs.push_back('{in: iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1),        exp: EN});
        vecs.push_back('{in: iv(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0),        exp: EN});
        vecs.push_back('{in: iv(1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0),        exp: EN});

        reset = 1'b1;
        {id_rs, id_rt, ex_write_reg, mem_write_reg} = '0;
        {id_uses_rt, id_is_branch, branch_taken, ex_mem_read, ex_reg_write} = '0;
        {mem_mem_read, dmem_req, dmem_ready} = '0;
        @(posedge clk);
        #1;

        // Reset behaviour and post-reset state.
        apply(idle, 1'b1, RS, "reset_ctrl");
        apply(lu, 1'b1, RS, "reset_ctrl_hz");
        chk("reset_stall_cnt", int'(stall_cnt), 0);
        chk("reset_flush_cnt", int'(flush_cnt), 0);
        chk("reset_timeout", int'(timeout), 0);

        // Single-cycle decision table, counters tracked by a saturating model.
        m_stall = 0;
        m_flush = 0;
        foreach (vecs[i]) begin
            apply(vecs[i].in, 1'b0, vecs[i].exp, $sformatf("vec%0d", i));
            if (vecs[i].exp[6] == 1'b0 && m_stall < 15) m_stall++;
            if (vecs[i].exp[1] == 1'b1 && m_flush < 15) m_flush++;
        end
        chk("table_stall_cnt", int'(stall_cnt), m_stall);
        chk("table_flush_cnt", int'(flush_cnt), m_flush);

        // Load feeding a branch: stall in EX, stall again in MEM, then flush.
        apply(idle, 1'b1, RS, "rst_a");
        apply(iv(1, 9, 1, 1, 1, 1, 1, 9, 0, 0, 0, 0), 1'b0, ST, "lb_ex");
        apply(iv(1, 9, 1, 1, 1, 0, 0, 0, 1, 9, 0, 0), 1'b0, ST, "lb_mem");
        apply(iv(1, 9, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, FL, "lb_flush");
        chk("lb_stall_cnt", int'(stall_cnt), 2);
        chk("lb_flush_cnt", int'(flush_cnt), 1);

        // Memory freeze outranks a live hazard, then the hazard stalls once back in RUN.
        apply(idle, 1'b1, RS, "rst_b");
        for (int i = 0; i < 3; i++) begin
            apply(iv(8, 0, 0, 0, 0, 1, 1, 8, 0, 0, 1, 0), 1'b0, FZ, $sformatf("frz%0d", i));
        end
        chk("frz_stall_cnt", int'(stall_cnt), 3);
        apply(iv(8, 0, 0, 0, 0, 1, 1, 8, 0, 0, 1, 1), 1'b0, EN, "frz_ready");
        chk("frz_ready_stall_cnt", int'(stall_cnt), 3);
        apply(lu, 1'b0, ST, "frz_then_hz");
        chk("frz_hz_stall_cnt", int'(stall_cnt), 4);

        // Reset during FREEZE drops back to RUN.
        apply(idle, 1'b1, RS, "rst_c");
        apply(iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0, FZ, "mid_frz0");
        apply(iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0, FZ, "mid_frz1");
        apply(iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1, RS, "mid_frz_rst");
        apply(idle, 1'b0, EN, "after_frz_rst");

        // Long freeze: timeout after 255 FREEZE cycles, sticky until reset.
        apply(idle, 1'b1, RS, "rst_d");
        for (int k = 1; k <= 300; k++) begin
            apply(iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0, FZ, "tmo_frz");
            if (k == 255) chk("tmo_before_limit", int'(timeout), 0);
            if (k == 256) chk("tmo_at_limit", int'(timeout), 1);
        end
        apply(iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 1'b0, EN, "tmo_ready");
        apply(iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 1'b0, EN, "tmo_run");
        chk("tmo_sticky", int'(timeout), 1);
        chk("tmo_stall_sat", int'(stall_cnt), 15);
        apply(idle, 1'b1, RS, "rst_e");
        chk("tmo_cleared", int'(timeout), 0);

        // Counter saturation.
        for (int k = 1; k <= 20; k++) begin
            apply(lu, 1'b0, ST, "sat_stall");
            if (k == 14) chk("stall_cnt_14", int'(stall_cnt), 14);
        end
        chk("stall_cnt_sat", int'(stall_cnt), 15);
        for (int k = 1; k <= 20; k++) begin
            apply(bt, 1'b0, FL, "sat_flush");
        end
        chk("flush_cnt_sat", int'(flush_cnt), 15);
        chk("stall_cnt_hold", int'(stall_cnt), 15);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
